// File: rtl/ps2_keyboard_decoder.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_decoder
//
// Purpose:
//   Receives PS/2 keyboard frames (scan code set 2) from the raw, asynchronous
//   PS/2 clock and data pins. Frames are re-timed into the system clock domain
//   and the PS/2 clock is glitch filtered. Bytes are validated by parity and
//   stop bit. The E0 (extended) and F0 (break) prefixes and the two shift keys
//   are tracked. The block reports the last scan byte, an ASCII translation
//   and one-cycle make/break pulses.
//
// Parameters:
//   FILTER_LEN      consecutive equal synchronized samples needed before a
//                   PS/2 clock level change is accepted
//   TIMEOUT_CYCLES  clk cycles without an accepted falling edge before a
//                   partially received frame is abandoned
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   ps2_clk_async   raw PS/2 clock pin, idle high
//   ps2_data_async  raw PS/2 data pin, idle high
//   scan_code       last completed non-prefix scan byte
//   ascii_code      ASCII of the last make code, 0x00 when unmapped
//   key_pressed     one-cycle pulse per make code (typematic repeats included)
//   key_released    one-cycle pulse per break code
// ---------------------------------------------------------------------------
module ps2_keyboard_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_async,
    input  logic       ps2_data_async,
    output logic [7:0] scan_code,
    output logic [7:0] ascii_code,
    output logic       key_pressed,
    output logic       key_released
);

    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;

    // Bit counter values: 0 waits for a start bit, 1..8 collect data,
    // 9 collects parity, 10 checks the stop bit.
    localparam logic [3:0] BIT_IDLE   = 4'd0;
    localparam logic [3:0] BIT_FIRST  = 4'd1;
    localparam logic [3:0] BIT_PARITY = 4'd9;

    // Synchronizer, filter and receiver state
    logic [1:0]        clkSync_q;
    logic [1:0]        datSync_q;
    logic              filtClk_q;
    logic [FILT_W-1:0] filtCnt_q;
    logic [3:0]        bitCnt_q,     bitCnt_d;
    logic [8:0]        frame_q,      frame_d;
    logic [TO_W-1:0]   timeoutCnt_q, timeoutCnt_d;
    logic              byteValid_q,  byteValid_d;
    logic [7:0]        rxByte_q,     rxByte_d;

    // Decoder state and registered outputs
    logic              breakFlag_q,  breakFlag_d;
    logic              extFlag_q,    extFlag_d;
    logic              shiftL_q,     shiftL_d;
    logic              shiftR_q,     shiftR_d;
    logic [7:0]        scanCode_q,   scanCode_d;
    logic [7:0]        asciiCode_q,  asciiCode_d;
    logic              keyPressed_q, keyPressed_d;
    logic              keyReleased_q, keyReleased_d;

    logic clkSample;
    logic dataSample;
    logic filtFlip;
    logic fallEdge;

    assign clkSample  = clkSync_q[1];
    assign dataSample = datSync_q[1];

    // Two-flop synchronizers for both pins. They reset to the idle-high level
    // so that leaving reset never looks like a falling clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clkSync_q <= 2'b11;
            datSync_q <= 2'b11;
        end else begin
            clkSync_q <= {clkSync_q[0], ps2_clk_async};
            datSync_q <= {datSync_q[0], ps2_data_async};
        end
    end

    // The filter flips its output on the FILTER_LEN-th consecutive sample that
    // disagrees with it. The falling edge is taken from the flip itself so the
    // data bit is sampled in the same cycle the edge is accepted.
    assign filtFlip = (clkSample != filtClk_q) &&
                      (filtCnt_q == FILT_W'(FILTER_LEN - 1));
    assign fallEdge = filtFlip && filtClk_q;

    // Glitch filter for the PS/2 clock: any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filtClk_q <= 1'b1;
            filtCnt_q <= '0;
        end else if (clkSample == filtClk_q) begin
            filtCnt_q <= '0;
        end else if (filtFlip) begin
            filtClk_q <= clkSample;
            filtCnt_q <= '0;
        end else begin
            filtCnt_q <= filtCnt_q + 1'b1;
        end
    end

    // Frame receiver. Data and parity shift in at the top of frame_q, so after
    // the parity bit the data byte sits LSB-first in frame_q[7:0] and parity in
    // frame_q[8]. An odd count of ones over all nine bits means good parity.
    // The timeout counter only runs while a frame is in progress and reloads
    // on every accepted edge.
    always_comb begin
        bitCnt_d     = bitCnt_q;
        frame_d      = frame_q;
        timeoutCnt_d = timeoutCnt_q;
        byteValid_d  = 1'b0;
        rxByte_d     = rxByte_q;

        if (fallEdge) begin
            timeoutCnt_d = '0;
            if (bitCnt_q == BIT_IDLE) begin
                if (!dataSample) begin
                    bitCnt_d = BIT_FIRST;
                end
            end else if (bitCnt_q <= BIT_PARITY) begin
                frame_d  = {dataSample, frame_q[8:1]};
                bitCnt_d = bitCnt_q + 4'd1;
            end else begin
                bitCnt_d = BIT_IDLE;
                if (dataSample && (^frame_q)) begin
                    byteValid_d = 1'b1;
                    rxByte_d    = frame_q[7:0];
                end
            end
        end else if (bitCnt_q != BIT_IDLE) begin
            if (timeoutCnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                bitCnt_d     = BIT_IDLE;
                timeoutCnt_d = '0;
            end else begin
                timeoutCnt_d = timeoutCnt_q + 1'b1;
            end
        end else begin
            timeoutCnt_d = '0;
        end
    end

    // Receiver registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitCnt_q     <= BIT_IDLE;
            frame_q      <= '0;
            timeoutCnt_q <= '0;
            byteValid_q  <= 1'b0;
            rxByte_q     <= '0;
        end else begin
            bitCnt_q     <= bitCnt_d;
            frame_q      <= frame_d;
            timeoutCnt_q <= timeoutCnt_d;
            byteValid_q  <= byteValid_d;
            rxByte_q     <= rxByte_d;
        end
    end

    // Scan code set 2 to ASCII. Letters are produced lowercase and lifted to
    // uppercase when shifted; digits and control keys ignore shift.
    function automatic logic [7:0] translate(input logic [7:0] code,
                                             input logic       shifted);
        logic [7:0] ch;
        ch = 8'h00;
        case (code)
            8'h1C: ch = "a";
            8'h32: ch = "b";
            8'h21: ch = "c";
            8'h23: ch = "d";
            8'h24: ch = "e";
            8'h2B: ch = "f";
            8'h34: ch = "g";
            8'h33: ch = "h";
            8'h43: ch = "i";
            8'h3B: ch = "j";
            8'h42: ch = "k";
            8'h4B: ch = "l";
            8'h3A: ch = "m";
            8'h31: ch = "n";
            8'h44: ch = "o";
            8'h4D: ch = "p";
            8'h15: ch = "q";
            8'h2D: ch = "r";
            8'h1B: ch = "s";
            8'h2C: ch = "t";
            8'h3C: ch = "u";
            8'h2A: ch = "v";
            8'h1D: ch = "w";
            8'h22: ch = "x";
            8'h35: ch = "y";
            8'h1A: ch = "z";
            8'h45: ch = "0";
            8'h16: ch = "1";
            8'h1E: ch = "2";
            8'h26: ch = "3";
            8'h25: ch = "4";
            8'h2E: ch = "5";
            8'h36: ch = "6";
            8'h3D: ch = "7";
            8'h3E: ch = "8";
            8'h46: ch = "9";
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0D;
            8'h66: ch = 8'h08;
            8'h76: ch = 8'h1B;
            8'h0D: ch = 8'h09;
            default: ch = 8'h00;
        endcase
        if (shifted && (ch >= "a") && (ch <= "z")) begin
            ch = ch - 8'h20;
        end
        return ch;
    endfunction

    // Byte interpreter. Prefix bytes only set flags. A break clears both
    // prefixes; a make clears only the extended flag. Shift tracking ignores
    // extended codes, so E0 12 (part of the fake-shift sequences some keys
    // send) never changes the shift state.
    always_comb begin
        scanCode_d    = scanCode_q;
        asciiCode_d   = asciiCode_q;
        keyPressed_d  = 1'b0;
        keyReleased_d = 1'b0;
        breakFlag_d   = breakFlag_q;
        extFlag_d     = extFlag_q;
        shiftL_d      = shiftL_q;
        shiftR_d      = shiftR_q;

        if (byteValid_q) begin
            if (rxByte_q == CODE_EXT) begin
                extFlag_d = 1'b1;
            end else if (rxByte_q == CODE_BREAK) begin
                breakFlag_d = 1'b1;
            end else if (breakFlag_q) begin
                scanCode_d    = rxByte_q;
                keyReleased_d = 1'b1;
                if (!extFlag_q && (rxByte_q == CODE_LSHIFT)) begin
                    shiftL_d = 1'b0;
                end
                if (!extFlag_q && (rxByte_q == CODE_RSHIFT)) begin
                    shiftR_d = 1'b0;
                end
                breakFlag_d = 1'b0;
                extFlag_d   = 1'b0;
            end else begin
                scanCode_d   = rxByte_q;
                asciiCode_d  = extFlag_q ? 8'h00
                                         : translate(rxByte_q, shiftL_q | shiftR_q);
                keyPressed_d = 1'b1;
                if (!extFlag_q && (rxByte_q == CODE_LSHIFT)) begin
                    shiftL_d = 1'b1;
                end
                if (!extFlag_q && (rxByte_q == CODE_RSHIFT)) begin
                    shiftR_d = 1'b1;
                end
                extFlag_d = 1'b0;
            end
        end
    end

    // Decoder registers. The codes update in the same edge that raises a
    // pulse, so they are valid whenever a pulse is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            breakFlag_q   <= 1'b0;
            extFlag_q     <= 1'b0;
            shiftL_q      <= 1'b0;
            shiftR_q      <= 1'b0;
            scanCode_q    <= 8'h00;
            asciiCode_q   <= 8'h00;
            keyPressed_q  <= 1'b0;
            keyReleased_q <= 1'b0;
        end else begin
            breakFlag_q   <= breakFlag_d;
            extFlag_q     <= extFlag_d;
            shiftL_q      <= shiftL_d;
            shiftR_q      <= shiftR_d;
            scanCode_q    <= scanCode_d;
            asciiCode_q   <= asciiCode_d;
            keyPressed_q  <= keyPressed_d;
            keyReleased_q <= keyReleased_d;
        end
    end

    assign scan_code    = scanCode_q;
    assign ascii_code   = asciiCode_q;
    assign key_pressed  = keyPressed_q;
    assign key_released = keyReleased_q;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_keyboard_decoder
//
// Drives PS/2 frames into ps2_keyboard_decoder and compares the pulses and
// codes against hand-written vectors and a behavioural keyboard model.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_decoder;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 200;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2Clk;
    logic       ps2Dat;
    logic [7:0] scanCode;
    logic [7:0] asciiCode;
    logic       keyPressed;
    logic       keyReleased;

    int checks = 0;
    int errors = 0;

    // Pulse monitor bookkeeping
    int         evTotal    = 0;
    int         evSeen     = 0;
    int         violations = 0;
    logic       evPress    = 1'b0;
    logic       evRel      = 1'b0;
    logic [7:0] evScan     = 8'h00;
    logic [7:0] evAscii    = 8'h00;
    logic       prevPulse  = 1'b0;

    // Behavioural keyboard model state
    logic       mBrk, mExt, mShiftL, mShiftR;
    logic [7:0] mScan, mAscii;

    logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                                     8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
                                     8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
    logic [7:0] digitCodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] ctrlCodes [5]   = '{8'h29, 8'h5A, 8'h66, 8'h76, 8'h0D};
    logic [7:0] ctrlAscii [5]   = '{8'h20, 8'h0D, 8'h08, 8'h1B, 8'h09};

    typedef struct {
        logic [7:0] code;
        logic       badPar;
        logic       badStop;
        int         kind;
        logic [7:0] scan;
        logic [7:0] ascii;
    } vec_t;

    vec_t vecs[$];

    ps2_keyboard_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ps2_clk_async (ps2Clk),
        .ps2_data_async(ps2Dat),
        .scan_code     (scanCode),
        .ascii_code    (asciiCode),
        .key_pressed   (keyPressed),
        .key_released  (keyReleased)
    );

    always #5 clk = ~clk;

    // Records every pulse with the codes seen in that same cycle, and counts
    // overlapping or back-to-back pulses.
    always @(negedge clk) begin
        if (keyPressed || keyReleased) begin
            evTotal = evTotal + 1;
            evPress = keyPressed;
            evRel   = keyReleased;
            evScan  = scanCode;
            evAscii = asciiCode;
            if ((keyPressed && keyReleased) || prevPulse) begin
                violations = violations + 1;
            end
        end
        prevPulse = keyPressed || keyReleased;
    end

    // Bound on total simulation length
    initial begin
        repeat (200000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] code,
                                              input logic badPar,
                                              input logic badStop);
        return {~badStop, (~^code) ^ badPar, code, 1'b0};
    endfunction

    // Sends nBits of a frame, bit 0 first. Data changes while the clock is
    // high; glitchAt selects a bit whose high phase gets a 2-cycle low pulse.
    task automatic driveBits(input logic [10:0] bits, input int nBits,
                             input int glitchAt);
        for (int i = 0; i < nBits; i++) begin
            ps2Dat = bits[i];
            repeat (HALF / 2) @(negedge clk);
            if (i == glitchAt) begin
                ps2Clk = 1'b0;
                repeat (2) @(negedge clk);
                ps2Clk = 1'b1;
            end
            repeat (HALF / 2) @(negedge clk);
            ps2Clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2Clk = 1'b1;
        end
        ps2Dat = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic badPar,
                                 input logic badStop, input int glitchAt);
        driveBits(makeFrame(code, badPar, badStop), 11, glitchAt);
        repeat (20) @(negedge clk);
        #1;
    endtask

    // kind: 0 no pulse, 1 make pulse, 2 break pulse
    task automatic checkOutput(input string name, input int kind,
                               input logic [7:0] expScan,
                               input logic [7:0] expAscii);
        int n;
        n      = evTotal - evSeen;
        evSeen = evTotal;
        compare({name, " pulseCount"}, n, (kind != 0) ? 1 : 0);
        if (kind != 0 && n == 1) begin
            compare({name, " pressFlag"}, evPress, (kind == 1) ? 1 : 0);
            compare({name, " releaseFlag"}, evRel, (kind == 2) ? 1 : 0);
            compare({name, " pulseScan"}, evScan, expScan);
            compare({name, " pulseAscii"}, evAscii, expAscii);
        end
        compare({name, " scan_code"}, scanCode, expScan);
        compare({name, " ascii_code"}, asciiCode, expAscii);
        compare({name, " exclusivity"}, violations, 0);
    endtask

    task automatic addVec(input logic [7:0] code, input logic badPar,
                          input logic badStop, input int kind,
                          input logic [7:0] scan, input logic [7:0] ascii);
        vec_t v;
        v.code = code; v.badPar = badPar; v.badStop = badStop;
        v.kind = kind; v.scan = scan;     v.ascii = ascii;
        vecs.push_back(v);
    endtask

    function automatic logic [7:0] modelAscii(input logic [7:0] code,
                                              input logic shifted);
        for (int i = 0; i < 26; i++)
            if (code == letterCodes[i])
                return (shifted ? 8'd65 : 8'd97) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (code == digitCodes[i])
                return 8'd48 + 8'(i);
        for (int i = 0; i < 5; i++)
            if (code == ctrlCodes[i])
                return ctrlAscii[i];
        return 8'h00;
    endfunction

    task automatic modelReset();
        mBrk = 0; mExt = 0; mShiftL = 0; mShiftR = 0;
        mScan = 8'h00; mAscii = 8'h00;
    endtask

    task automatic modelStep(input logic [7:0] code, input logic bad,
                             output int kind);
        kind = 0;
        if (bad) return;
        if (code == 8'hE0) mExt = 1;
        else if (code == 8'hF0) mBrk = 1;
        else if (mBrk) begin
            mScan = code;
            kind  = 2;
            if (!mExt && code == 8'h12) mShiftL = 0;
            if (!mExt && code == 8'h59) mShiftR = 0;
            mBrk = 0;
            mExt = 0;
        end else begin
            mScan  = code;
            mAscii = mExt ? 8'h00 : modelAscii(code, mShiftL | mShiftR);
            kind   = 1;
            if (!mExt && code == 8'h12) mShiftL = 1;
            if (!mExt && code == 8'h59) mShiftR = 1;
            mExt = 0;
        end
    endtask

    function automatic logic [7:0] pickCode();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 8'hE0;
            1: return 8'hF0;
            2: return 8'h12;
            3: return 8'h59;
            4, 5: return letterCodes[$urandom_range(0, 25)];
            6: return digitCodes[$urandom_range(0, 9)];
            7: return ctrlCodes[$urandom_range(0, 4)];
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic applyReset();
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        evSeen = evTotal;
        modelReset();
    endtask

    initial begin
        int kind;
        logic [7:0] code;
        logic badPar, badStop;

        ps2Clk  = 1'b1;
        ps2Dat  = 1'b1;
        reset_n = 1'b0;

        // Reset held while a complete frame toggles the pins
        repeat (3) @(negedge clk);
        driveBits(makeFrame(8'h1C, 1'b0, 1'b0), 11, -1);
        repeat (20) @(negedge clk);
        #1;
        compare("resetHold key_pressed", keyPressed, 0);
        compare("resetHold key_released", keyReleased, 0);
        checkOutput("resetHold", 0, 8'h00, 8'h00);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Table-driven vectors, starting from a clean state
        addVec(8'h1C, 0, 0, 1, 8'h1C, 8'h61);
        addVec(8'hF0, 0, 0, 0, 8'h1C, 8'h61);
        addVec(8'h1C, 0, 0, 2, 8'h1C, 8'h61);
        addVec(8'h12, 0, 0, 1, 8'h12, 8'h00);
        addVec(8'h1C, 0, 0, 1, 8'h1C, 8'h41);
        addVec(8'hF0, 0, 0, 0, 8'h1C, 8'h41);
        addVec(8'h12, 0, 0, 2, 8'h12, 8'h41);
        addVec(8'h1C, 0, 0, 1, 8'h1C, 8'h61);
        addVec(8'hE0, 0, 0, 0, 8'h1C, 8'h61);
        addVec(8'h75, 0, 0, 1, 8'h75, 8'h00);
        addVec(8'hE0, 0, 0, 0, 8'h75, 8'h00);
        addVec(8'h12, 0, 0, 1, 8'h12, 8'h00);
        addVec(8'h1C, 0, 0, 1, 8'h1C, 8'h61);
        addVec(8'h1C, 1, 0, 0, 8'h1C, 8'h61);
        addVec(8'h29, 0, 1, 0, 8'h1C, 8'h61);
        addVec(8'h29, 0, 0, 1, 8'h29, 8'h20);
        addVec(8'h59, 0, 0, 1, 8'h59, 8'h00);
        addVec(8'h16, 0, 0, 1, 8'h16, 8'h31);
        addVec(8'h15, 0, 0, 1, 8'h15, 8'h51);
        addVec(8'hE0, 0, 0, 0, 8'h15, 8'h51);
        addVec(8'hF0, 0, 0, 0, 8'h15, 8'h51);
        addVec(8'h59, 0, 0, 2, 8'h59, 8'h51);
        addVec(8'h2D, 0, 0, 1, 8'h2D, 8'h52);
        addVec(8'hF0, 0, 0, 0, 8'h2D, 8'h52);
        addVec(8'h59, 0, 0, 2, 8'h59, 8'h52);
        addVec(8'h2D, 0, 0, 1, 8'h2D, 8'h72);
        addVec(8'h5A, 0, 0, 1, 8'h5A, 8'h0D);
        addVec(8'h76, 0, 0, 1, 8'h76, 8'h1B);
        addVec(8'hE0, 0, 0, 0, 8'h76, 8'h1B);
        addVec(8'hF0, 0, 0, 0, 8'h76, 8'h1B);
        addVec(8'h75, 0, 0, 2, 8'h75, 8'h1B);
        addVec(8'h0D, 0, 0, 1, 8'h0D, 8'h09);
        addVec(8'h66, 0, 0, 1, 8'h66, 8'h08);
        addVec(8'hF0, 1, 0, 0, 8'h66, 8'h08);
        addVec(8'h1C, 0, 0, 1, 8'h1C, 8'h61);
        addVec(8'h0E, 0, 0, 1, 8'h0E, 8'h00);
        addVec(8'hE0, 0, 0, 0, 8'h0E, 8'h00);
        addVec(8'h1C, 0, 0, 1, 8'h1C, 8'h00);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].code, vecs[i].badPar, vecs[i].badStop, -1);
            checkOutput($sformatf("vec%0d", i), vecs[i].kind,
                        vecs[i].scan, vecs[i].ascii);
        end

        // Partial frame abandoned by the timeout, then a full frame
        driveBits(makeFrame(8'h1C, 1'b0, 1'b0), 5, -1);
        repeat (TIMEOUT + 100) @(negedge clk);
        #1;
        checkOutput("timeoutIdle", 0, 8'h1C, 8'h00);
        applyStimulus(8'h45, 1'b0, 1'b0, -1);
        checkOutput("timeoutFrame", 1, 8'h45, 8'h30);

        // Short clock glitch inside a frame is filtered out
        applyStimulus(8'h1C, 1'b0, 1'b0, 4);
        checkOutput("glitchFrame", 1, 8'h1C, 8'h61);

        // Reset in the middle of a frame
        driveBits(makeFrame(8'h32, 1'b0, 1'b0), 5, -1);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        compare("midReset key_pressed", keyPressed, 0);
        compare("midReset scan_code", scanCode, 0);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        checkOutput("midResetIdle", 0, 8'h00, 8'h00);
        applyStimulus(8'h1C, 1'b0, 1'b0, -1);
        checkOutput("midResetFrame", 1, 8'h1C, 8'h61);

        // Randomized frames against the keyboard model
        applyReset();
        for (int i = 0; i < 40; i++) begin
            code    = pickCode();
            badPar  = ($urandom_range(0, 9) == 0);
            badStop = ($urandom_range(0, 14) == 0);
            modelStep(code, badPar | badStop, kind);
            applyStimulus(code, badPar, badStop, -1);
            checkOutput($sformatf("rand%0d code=%02h", i, code), kind, mScan, mAscii);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
